// File: rtl/ascon_dma_sched.sv
// Job sequencer for the ASCON DMA channels: latches one descriptor, then issues the key read,
// the paired bdi read / bdo write and the tag write in order, each gated on its channel's done pulse.
module ascon_dma_sched #(
   parameter int unsigned KeyBytes  = 16,
   parameter int unsigned TagBytes  = 16,
   parameter int unsigned ToutWidth = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic [31:0] key_addr_i,
   input  logic [31:0] bdi_addr_i,
   input  logic [31:0] bdo_addr_i,
   input  logic [31:0] tag_addr_i,
   input  logic [31:0] bdi_len_i,
   output logic        key_arvalid_o,
   input  logic        key_arready_i,
   output logic        bdi_arvalid_o,
   input  logic        bdi_arready_i,
   output logic        bdo_awvalid_o,
   input  logic        bdo_awready_i,
   output logic        tag_awvalid_o,
   input  logic        tag_awready_i,
   output logic [31:0] key_araddr_o,
   output logic [31:0] bdi_araddr_o,
   output logic [31:0] bdo_awaddr_o,
   output logic [31:0] tag_awaddr_o,
   output logic [31:0] key_arlen_o,
   output logic [31:0] bdi_arlen_o,
   output logic [31:0] bdo_awlen_o,
   output logic [31:0] tag_awlen_o,
   input  logic        key_done_i,
   input  logic        bdi_done_i,
   input  logic        bdo_done_i,
   input  logic        tag_done_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [2:0]  state_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_KEY_REQ, S_KEY_WAIT, S_DATA_REQ, S_DATA_WAIT, S_TAG_REQ, S_TAG_WAIT, S_DONE
   } state_e;

   state_e               state_q;
   logic [ToutWidth-1:0] wd_q;
   logic [ToutWidth-1:0] wd_inc;
   logic                 tout;
   logic                 key_f, bdi_f, bdo_f, tag_f;
   logic [31:0]          len_q;

   // Command channels: a command transfers on a cycle with valid && ready; once raised, valid and
   // its addr/len stay fixed until that transfer (only abort or reset may drop it early).
   assign wd_inc = (&wd_q) ? wd_q : wd_q + ToutWidth'(1);
   assign tout   = &wd_inc;

   assign key_arlen_o = 32'(KeyBytes);
   assign tag_awlen_o = 32'(TagBytes);
   assign bdi_arlen_o = len_q;
   assign bdo_awlen_o = len_q;
   assign state_o     = state_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         wd_q          <= '0;
         {key_f, bdi_f, bdo_f, tag_f} <= '0;
         len_q         <= '0;
         key_araddr_o  <= '0;
         bdi_araddr_o  <= '0;
         bdo_awaddr_o  <= '0;
         tag_awaddr_o  <= '0;
         key_arvalid_o <= 1'b0;
         bdi_arvalid_o <= 1'b0;
         bdo_awvalid_o <= 1'b0;
         tag_awvalid_o <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         err_o         <= 1'b0;
      end else begin
         done_o <= 1'b0;
         // Done pulses are captured from the REQ cycle onwards so a pulse racing the handshake counts.
         if (state_q inside {S_KEY_REQ, S_KEY_WAIT})   key_f <= key_f | key_done_i;
         if (state_q inside {S_DATA_REQ, S_DATA_WAIT}) bdi_f <= bdi_f | bdi_done_i;
         if (state_q inside {S_DATA_REQ, S_DATA_WAIT}) bdo_f <= bdo_f | bdo_done_i;
         if (state_q inside {S_TAG_REQ, S_TAG_WAIT})   tag_f <= tag_f | tag_done_i;
         if (state_q inside {S_KEY_WAIT, S_DATA_WAIT, S_TAG_WAIT}) wd_q <= wd_inc;

         if (abort_i && state_q != S_IDLE) begin
            state_q       <= S_IDLE;
            wd_q          <= '0;
            {key_f, bdi_f, bdo_f, tag_f} <= '0;
            key_arvalid_o <= 1'b0;
            bdi_arvalid_o <= 1'b0;
            bdo_awvalid_o <= 1'b0;
            tag_awvalid_o <= 1'b0;
            busy_o        <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: if (start_i) begin
                  key_araddr_o  <= key_addr_i;
                  bdi_araddr_o  <= bdi_addr_i;
                  bdo_awaddr_o  <= bdo_addr_i;
                  tag_awaddr_o  <= tag_addr_i;
                  len_q         <= bdi_len_i;
                  err_o         <= 1'b0;
                  busy_o        <= 1'b1;
                  key_arvalid_o <= 1'b1;
                  key_f         <= 1'b0;
                  wd_q          <= '0;
                  state_q       <= S_KEY_REQ;
               end
               S_KEY_REQ: if (key_arready_i) begin
                  key_arvalid_o <= 1'b0;
                  wd_q          <= '0;
                  state_q       <= S_KEY_WAIT;
               end
               S_KEY_WAIT: if (key_f) begin
                  wd_q <= '0;
                  if (len_q != 32'd0) begin
                     bdi_arvalid_o <= 1'b1;
                     bdo_awvalid_o <= 1'b1;
                     bdi_f         <= 1'b0;
                     bdo_f         <= 1'b0;
                     state_q       <= S_DATA_REQ;
                  end else begin
                     tag_awvalid_o <= 1'b1;
                     tag_f         <= 1'b0;
                     state_q       <= S_TAG_REQ;
                  end
               end else if (tout) begin
                  wd_q    <= '0;
                  err_o   <= 1'b1;
                  busy_o  <= 1'b0;
                  state_q <= S_IDLE;
               end
               S_DATA_REQ: begin
                  if (bdi_arready_i) bdi_arvalid_o <= 1'b0;
                  if (bdo_awready_i) bdo_awvalid_o <= 1'b0;
                  if ((!bdi_arvalid_o || bdi_arready_i) && (!bdo_awvalid_o || bdo_awready_i)) begin
                     wd_q    <= '0;
                     state_q <= S_DATA_WAIT;
                  end
               end
               S_DATA_WAIT: if (bdi_f && bdo_f) begin
                  wd_q          <= '0;
                  tag_awvalid_o <= 1'b1;
                  tag_f         <= 1'b0;
                  state_q       <= S_TAG_REQ;
               end else if (tout) begin
                  wd_q    <= '0;
                  err_o   <= 1'b1;
                  busy_o  <= 1'b0;
                  state_q <= S_IDLE;
               end
               S_TAG_REQ: if (tag_awready_i) begin
                  tag_awvalid_o <= 1'b0;
                  wd_q          <= '0;
                  state_q       <= S_TAG_WAIT;
               end
               S_TAG_WAIT: if (tag_f) begin
                  wd_q    <= '0;
                  done_o  <= 1'b1;
                  state_q <= S_DONE;
               end else if (tout) begin
                  wd_q    <= '0;
                  err_o   <= 1'b1;
                  busy_o  <= 1'b0;
                  state_q <= S_IDLE;
               end
               S_DONE: begin
                  busy_o  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ascon_dma_sched.sv
// Directed bench for ascon_dma_sched: channel responder, command-order scoreboard and stepwise checks.
module tb_ascon_dma_sched;
   localparam int TW = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i, abort_i;
   logic [31:0] key_addr_i, bdi_addr_i, bdo_addr_i, tag_addr_i, bdi_len_i;
   logic        key_arready_i, bdi_arready_i, bdo_awready_i, tag_awready_i;
   logic        key_done_i, bdi_done_i, bdo_done_i, tag_done_i;
   logic        key_arvalid_o, bdi_arvalid_o, bdo_awvalid_o, tag_awvalid_o;
   logic [31:0] key_araddr_o, bdi_araddr_o, bdo_awaddr_o, tag_awaddr_o;
   logic [31:0] key_arlen_o, bdi_arlen_o, bdo_awlen_o, tag_awlen_o;
   logic        busy_o, done_o, err_o;
   logic [2:0]  state_o;

   always #5 clk_i = ~clk_i;

   ascon_dma_sched #(.KeyBytes(16), .TagBytes(16), .ToutWidth(TW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .key_addr_i(key_addr_i), .bdi_addr_i(bdi_addr_i), .bdo_addr_i(bdo_addr_i),
      .tag_addr_i(tag_addr_i), .bdi_len_i(bdi_len_i),
      .key_arvalid_o(key_arvalid_o), .key_arready_i(key_arready_i),
      .bdi_arvalid_o(bdi_arvalid_o), .bdi_arready_i(bdi_arready_i),
      .bdo_awvalid_o(bdo_awvalid_o), .bdo_awready_i(bdo_awready_i),
      .tag_awvalid_o(tag_awvalid_o), .tag_awready_i(tag_awready_i),
      .key_araddr_o(key_araddr_o), .bdi_araddr_o(bdi_araddr_o),
      .bdo_awaddr_o(bdo_awaddr_o), .tag_awaddr_o(tag_awaddr_o),
      .key_arlen_o(key_arlen_o), .bdi_arlen_o(bdi_arlen_o),
      .bdo_awlen_o(bdo_awlen_o), .tag_awlen_o(tag_awlen_o),
      .key_done_i(key_done_i), .bdi_done_i(bdi_done_i),
      .bdo_done_i(bdo_done_i), .tag_done_i(tag_done_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .state_o(state_o)
   );

   int checks = 0;
   int failures = 0;

   // channel index: 0 key, 1 bdi, 2 bdo, 3 tag
   logic [3:0]  rdy, auto_en, man_done, resp_done, vld;
   logic [31:0] addr [4];
   logic [31:0] len [4];
   int          dly [4];
   int          cnt [4];

   assign vld = {tag_awvalid_o, bdo_awvalid_o, bdi_arvalid_o, key_arvalid_o};
   assign {tag_awready_i, bdo_awready_i, bdi_arready_i, key_arready_i} = rdy;
   assign {tag_done_i, bdo_done_i, bdi_done_i, key_done_i} = resp_done | man_done;
   assign addr[0] = key_araddr_o;
   assign addr[1] = bdi_araddr_o;
   assign addr[2] = bdo_awaddr_o;
   assign addr[3] = tag_awaddr_o;
   assign len[0]  = key_arlen_o;
   assign len[1]  = bdi_arlen_o;
   assign len[2]  = bdo_awlen_o;
   assign len[3]  = tag_awlen_o;

   // responder: one done pulse dly[c] cycles after each accepted command
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int c = 0; c < 4; c++) cnt[c] = 0;
         resp_done = '0;
      end else begin : resp
         logic [3:0] h;
         h = vld & rdy;
         #1;
         for (int c = 0; c < 4; c++) begin
            resp_done[c] = (cnt[c] == 1);
            if (cnt[c] > 0) cnt[c] = cnt[c] - 1;
            if (h[c] && auto_en[c]) cnt[c] = dly[c];
         end
      end
   end

   // scoreboard: accepted command order, done pulses, valid/payload stability
   logic [1:0]  exp_q[$];
   logic [1:0]  got_q[$];
   logic [3:0]  last_v = '0, last_r = '0;
   logic [31:0] last_a [4];
   logic [31:0] last_l [4];
   logic        last_abort = 1'b1;
   int          viol = 0, done_cnt = 0;
   logic        bd_seen = 1'b0;

   always @(posedge clk_i) begin
      if (!rst_i) begin
         for (int c = 0; c < 4; c++) begin
            if (last_v[c] && !last_r[c] && !last_abort &&
                !(vld[c] && addr[c] == last_a[c] && len[c] == last_l[c])) viol++;
            if (vld[c] && rdy[c]) got_q.push_back(2'(c));
         end
         if (done_o) done_cnt++;
         if (vld[1] || vld[2]) bd_seen = 1'b1;
      end
      last_v = vld;
      last_r = rdy;
      for (int c = 0; c < 4; c++) begin
         last_a[c] = addr[c];
         last_l[c] = len[c];
      end
      last_abort = abort_i | rst_i;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_sb();
      got_q.delete();
      done_cnt = 0;
      viol = 0;
      bd_seen = 1'b0;
   endtask

   task automatic start_job(input logic [31:0] k, input logic [31:0] bi, input logic [31:0] bo,
                            input logic [31:0] t, input logic [31:0] l);
      key_addr_i = k; bdi_addr_i = bi; bdo_addr_i = bo; tag_addr_i = t; bdi_len_i = l;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic run_to_idle(input string tag, input int budget, output int nd, output logic bad);
      nd = 0;
      bad = 1'b0;
      for (int i = 0; i < budget && busy_o; i++) begin
         tick();
         if (done_o) begin
            nd++;
            bad = busy_o;
         end
      end
      check(tag, busy_o, 0);
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
      for (int i = 0; i < budget && state_o != s; i++) tick();
      check(tag, state_o, s);
   endtask

   task automatic check_order(input string tag);
      check({tag, "_order_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check({tag, "_order_item"}, got_q[i], exp_q[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int   nd;
      int   n;
      logic bad;
      rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
      key_addr_i = '0; bdi_addr_i = '0; bdo_addr_i = '0; tag_addr_i = '0; bdi_len_i = '0;
      rdy = '0; auto_en = '0; man_done = '0;
      for (int c = 0; c < 4; c++) dly[c] = 5;
      repeat (3) tick();
      check("rst_busy", busy_o, 0);
      check("rst_valids", vld, 0);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      check("rst_state", state_o, 0);
      check("rst_key_addr", key_araddr_o, 0);
      check("rst_bdi_len", bdi_arlen_o, 0);
      rst_i = 1'b0;
      tick();

      // basic job, all channels ready, dones 5 cycles after each handshake
      rdy = 4'hf; auto_en = 4'hf; clear_sb();
      start_job(32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'd37);
      check("t1_busy_start", busy_o, 1);
      check("t1_key_valid", key_arvalid_o, 1);
      check("t1_key_addr", key_araddr_o, 32'h1000);
      check("t1_key_len", key_arlen_o, 16);
      run_to_idle("t1_idle", 200, nd, bad);
      check("t1_done_cycles", nd, 1);
      check("t1_busy_at_done", bad, 1);
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
      check_order("t1");
      check("t1_bdi_addr", bdi_araddr_o, 32'h2000);
      check("t1_bdo_addr", bdo_awaddr_o, 32'h3000);
      check("t1_tag_addr", tag_awaddr_o, 32'h4000);
      check("t1_bdi_len", bdi_arlen_o, 37);
      check("t1_bdo_len", bdo_awlen_o, 37);
      check("t1_tag_len", tag_awlen_o, 16);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_stable", viol, 0);

      // zero length skips the data phase
      clear_sb();
      start_job(32'h5000, 32'h6000, 32'h7000, 32'h8000, 32'd0);
      run_to_idle("t2_idle", 200, nd, bad);
      exp_q = '{2'd0, 2'd3};
      check_order("t2");
      check("t2_bd_never_valid", bd_seen, 0);
      check("t2_done_cnt", done_cnt, 1);

      // bdo accepted late, bdo done before bdi done
      rdy = 4'b1011; auto_en = 4'b1001; clear_sb();
      start_job(32'h1100, 32'h2200, 32'h3300, 32'h4400, 32'd8);
      wait_state("t3_reach_data_req", 3'd3, 50);
      check("t3_both_valid", {bdi_arvalid_o, bdo_awvalid_o}, 2'b11);
      tick();
      check("t3_bdi_dropped", {bdi_arvalid_o, bdo_awvalid_o}, 2'b01);
      check("t3_still_req", state_o, 3);
      tick();
      tick();
      check("t3_bdo_held", bdo_awvalid_o, 1);
      check("t3_bdo_addr", bdo_awaddr_o, 32'h3300);
      rdy[2] = 1'b1;
      tick();
      check("t3_bdo_dropped", bdo_awvalid_o, 0);
      check("t3_data_wait", state_o, 4);
      man_done[2] = 1'b1;
      tick();
      man_done[2] = 1'b0;
      tick();
      check("t3_wait_bdi", state_o, 4);
      check("t3_no_tag_yet", tag_awvalid_o, 0);
      man_done[1] = 1'b1;
      tick();
      man_done[1] = 1'b0;
      check("t3_flag_cycle", state_o, 4);
      tick();
      check("t3_tag_req", tag_awvalid_o, 1);
      run_to_idle("t3_idle", 200, nd, bad);
      check("t3_done_cnt", done_cnt, 1);
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
      check_order("t3");
      check("t3_stable", viol, 0);

      // tag done never arrives: watchdog
      rdy = 4'hf; auto_en = 4'b0111; clear_sb();
      start_job(32'h10, 32'h20, 32'h30, 32'h40, 32'd0);
      wait_state("t4_reach_tag_wait", 3'd6, 60);
      n = 0;
      while (state_o == 3'd6 && n < 40) begin
         n++;
         tick();
      end
      check("t4_wait_cycles", n, 15);
      check("t4_err", err_o, 1);
      check("t4_idle", state_o, 0);
      check("t4_busy", busy_o, 0);
      check("t4_no_done", done_cnt, 0);
      tick();
      check("t4_err_sticky", err_o, 1);
      auto_en = 4'hf; clear_sb();
      start_job(32'h10, 32'h20, 32'h30, 32'h40, 32'd0);
      check("t4_err_cleared", err_o, 0);
      run_to_idle("t4_rerun_idle", 200, nd, bad);
      check("t4_rerun_done", done_cnt, 1);

      // abort while bdi read is pending
      rdy = 4'b1001; clear_sb();
      start_job(32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'd16);
      wait_state("t5_reach_data_req", 3'd3, 50);
      tick();
      check("t5_bdi_held", bdi_arvalid_o, 1);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check("t5_valids_low", vld, 0);
      check("t5_busy", busy_o, 0);
      check("t5_state", state_o, 0);
      check("t5_err_unchanged", err_o, 0);
      check("t5_no_done", done_cnt, 0);
      rdy = 4'hf; clear_sb();
      start_job(32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'd16);
      run_to_idle("t5_rerun_idle", 200, nd, bad);
      check("t5_rerun_done", done_cnt, 1);
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
      check_order("t5");

      // key done in the handshake cycle; start while busy is ignored
      rdy = 4'b1110; auto_en = 4'b1110; clear_sb();
      start_job(32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000, 32'd5);
      check("t6_key_valid", key_arvalid_o, 1);
      rdy[0] = 1'b1; man_done[0] = 1'b1;
      tick();
      rdy[0] = 1'b0; man_done[0] = 1'b0;
      check("t6_key_wait", state_o, 2);
      start_job(32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'd99);
      check("t6_key_addr_kept", key_araddr_o, 32'h1111_0000);
      check("t6_len_kept", bdi_arlen_o, 5);
      run_to_idle("t6_idle", 200, nd, bad);
      check("t6_done_cycles", nd, 1);
      check("t6_bdo_addr", bdo_awaddr_o, 32'h3333_0000);
      check("t6_tag_addr", tag_awaddr_o, 32'h4444_0000);
      repeat (3) tick();
      check("t6_no_second_job", busy_o, 0);
      check("t6_done_cnt", done_cnt, 1);
      exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
      check_order("t6");

      // asynchronous reset mid-job
      rdy = '0;
      start_job(32'h77, 32'h88, 32'h99, 32'hAA, 32'd4);
      check("t7_key_valid", key_arvalid_o, 1);
      #2 rst_i = 1'b1;
      #1;
      check("t7_async_valid", key_arvalid_o, 0);
      check("t7_async_busy", busy_o, 0);
      check("t7_async_addr", key_araddr_o, 0);
      #2 rst_i = 1'b0;
      tick();
      check("t7_idle", state_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
